maze_grid_tracker: RTL
======================

# maze_grid_tracker

Parametrised maze-state store and tile renderer between the robot radio/packet interface and the VGA driver. Accepts strobed position and marking packets, keeps a ROWS×COLS grid of 2-bit cell states, and tracks the robot's current cell. For every pixel coordinate from the VGA driver it returns a registered 8-bit RRRGGGBB colour. Generalises the fixed 4×5, level-sensitive grid logic to any grid size and tile size, and adds a valid/ready handshake, a frontier-marking command, a sweep clear and a visited counter.

## Interface
Parameters:
- ROWS, 4, grid rows (≥2)
- COLS, 5, grid columns (≥2)
- TILE_PX, 50, tile edge in pixels; ROWS·TILE_PX ≤ 480 and COLS·TILE_PX ≤ 640
- Derived localparams: ROW_W = $clog2(ROWS), COL_W = $clog2(COLS), CNT_W = $clog2(ROWS·COLS+1)

Ports:
- CLOCK  in  1  system clock (25 MHz VGA clock)
- RESET  in  1  synchronous, active-high reset
- PKT_VALID  in  1  packet strobe
- PKT_READY  out  1  block can accept a packet
- PKT_KIND  in  2  0 MOVE, 1 MARK_FUTURE, 2 CLEAR_ALL, 3 reserved
- PKT_ROW  in  ROW_W  target row
- PKT_COL  in  COL_W  target column
- PIXEL_X  in  10  current x coordinate from the VGA driver
- PIXEL_Y  in  10  current y coordinate from the VGA driver
- PIXEL_COLOR  out  8  colour for the previous cycle's coordinate
- CUR_VALID  out  1  robot position is known
- CUR_ROW  out  ROW_W  current row
- CUR_COL  out  COL_W  current column
- VISITED_COUNT  out  CNT_W  number of cells in VISITED or CURRENT

## Operation
- Cell states: UNVISITED=0, VISITED=1, CURRENT=2, FUTURE=3. Colours: red 8'hE0, blue 8'h03, green 8'h1C, yellow 8'hFC. Background outside the grid: black 8'h00.
- FSM states: IDLE and SWEEP. PKT_READY = (state==IDLE).
- A packet is accepted when PKT_VALID && PKT_READY. A packet with PKT_ROW ≥ ROWS or PKT_COL ≥ COLS is accepted and otherwise ignored. Kind 3 is accepted and ignored.
- MOVE:
  - Target cell becomes CURRENT.
  - If CUR_VALID and the old position differs from the target, the old cell becomes VISITED.
  - CUR_ROW/CUR_COL are loaded and CUR_VALID is set.
  - VISITED_COUNT increments only if the target was UNVISITED or FUTURE.
  - MOVE onto the current cell: no change.
- MARK_FUTURE: target becomes FUTURE only if it is UNVISITED; otherwise no change.
- CLEAR_ALL:
  - At acceptance, CUR_VALID is cleared and VISITED_COUNT is zeroed.
  - The FSM enters SWEEP and writes UNVISITED to one cell per cycle in row-major order, from (0,0) to (ROWS-1,COLS-1), then returns to IDLE.
  - Rendering continues throughout the sweep.
- Pixel lookup:
  - row = PIXEL_Y / TILE_PX and col = PIXEL_X / TILE_PX, using half-open tiles [k·TILE_PX, (k+1)·TILE_PX).
  - A coordinate is inside the grid iff PIXEL_X < COLS·TILE_PX and PIXEL_Y < ROWS·TILE_PX.

## Timing
- Reset, in one cycle: all cells UNVISITED, state IDLE, PKT_READY=1, CUR_VALID=0, CUR_ROW=0, CUR_COL=0, VISITED_COUNT=0, PIXEL_COLOR=8'h00.
- RESET asserted during SWEEP aborts the sweep; the reset values above apply.
- Grid updates are visible to rendering on the edge after acceptance. PIXEL_COLOR reflects the grid state at the sample edge.
- PIXEL_COLOR latency is exactly 1 cycle from PIXEL_X/PIXEL_Y.
- CLEAR_ALL occupies ROWS·COLS cycles in SWEEP. PKT_READY is low for exactly those cycles and rises on the edge after the last cell write.
- Back-to-back packets in IDLE are accepted every cycle. Each one sees the grid as updated by the previous packet.
- VISITED_COUNT saturates at ROWS·COLS (unreachable in legal use).

## Configuration
- MAZE_GRID_BORDER_EN defined: in-grid pixels with (x mod TILE_PX)==0 or (y mod TILE_PX)==0 render white 8'hFF, overriding the cell colour. Latency is unchanged.
- MAZE_GRID_BORDER_EN undefined: no border logic; every in-grid pixel shows its cell colour.

## Structure
- Package maze_grid_pkg holds:
  - cell_state_t (2-bit enum)
  - pkt_kind_t (2-bit enum)
  - colour constants COLOR_UNVISITED, COLOR_VISITED, COLOR_CURRENT, COLOR_FUTURE, COLOR_BG, COLOR_BORDER
- Sub-module maze_tile_locator maps PIXEL_X/PIXEL_Y to row, col, in_grid and on_border. It is purely combinational, parametrised by ROWS, COLS and TILE_PX, and uses a compare chain against tile multiples (no divider).
- The grid is a ROWS·COLS register array inside maze_grid_tracker.

## Test plan
- Reset, then sweep PIXEL_X/Y over (0,0), (249,199) and (250,0) → colours 8'hE0, 8'hE0, 8'h00 one cycle later; PKT_READY=1, VISITED_COUNT=0.
- MOVE (0,0) then MOVE (1,2) → cell (0,0)=VISITED, blue at pixel (10,10); cell (1,2)=CURRENT, green at pixel (110,60); CUR_ROW=1, CUR_COL=2, VISITED_COUNT=2.
- MARK_FUTURE (3,4), then MARK_FUTURE on visited cell (0,0) → pixel (210,160) is 8'hFC; (0,0) stays blue. MOVE (3,4) → VISITED_COUNT increments.
- CLEAR_ALL with PKT_VALID held high → PKT_READY low for exactly 20 cycles, CUR_VALID=0 on the next edge, all tiles red afterwards, and the held packet is accepted on the first ready cycle.
- MOVE with PKT_ROW=3, PKT_COL=7 (out of range, COLS=5) → accepted, no state or counter change. Assert RESET mid-sweep → reset values on the next edge.
- With MAZE_GRID_BORDER_EN defined → pixel (50,10) is 8'hFF and pixel (51,10) shows the cell colour; with the macro undefined, (50,10) shows the cell colour.

Source files
------------

// File: rtl/maze_grid_pkg.sv
// -----------------------------------------------------------------------------
// maze_grid_pkg
// Shared types and constants for the maze grid tracker:
//   cell_state_t    - 2-bit per-cell state stored in the grid
//   pkt_kind_t      - 2-bit packet command code
//   tracker_state_t - control FSM state (IDLE / SWEEP)
//   COLOR_*         - 8-bit RRRGGGBB colours used by the renderer
//   cell_color()    - maps a cell state to its tile colour
// -----------------------------------------------------------------------------
package maze_grid_pkg;

    typedef enum logic [1:0] {
        CELL_UNVISITED = 2'd0,
        CELL_VISITED   = 2'd1,
        CELL_CURRENT   = 2'd2,
        CELL_FUTURE    = 2'd3
    } cell_state_t;

    typedef enum logic [1:0] {
        KIND_MOVE        = 2'd0,
        KIND_MARK_FUTURE = 2'd1,
        KIND_CLEAR_ALL   = 2'd2,
        KIND_RESERVED    = 2'd3
    } pkt_kind_t;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } tracker_state_t;

    localparam logic [7:0] COLOR_UNVISITED = 8'hE0;
    localparam logic [7:0] COLOR_VISITED   = 8'h03;
    localparam logic [7:0] COLOR_CURRENT   = 8'h1C;
    localparam logic [7:0] COLOR_FUTURE    = 8'hFC;
    localparam logic [7:0] COLOR_BG        = 8'h00;
    localparam logic [7:0] COLOR_BORDER    = 8'hFF;

    function automatic logic [7:0] cell_color(input cell_state_t s);
        logic [7:0] c;
        case (s)
            CELL_UNVISITED: c = COLOR_UNVISITED;
            CELL_VISITED:   c = COLOR_VISITED;
            CELL_CURRENT:   c = COLOR_CURRENT;
            CELL_FUTURE:    c = COLOR_FUTURE;
            default:        c = COLOR_BG;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/maze_tile_locator.sv
// -----------------------------------------------------------------------------
// maze_tile_locator
// Purely combinational pixel-to-tile mapper. Row/column are found with a
// compare chain against tile multiples, so no divider is needed.
// Optional feature macro: MAZE_GRID_BORDER_EN (drives on_border; otherwise 0).
// Ports:
//   pixel_x, pixel_y (in, 10)  - VGA coordinate
//   row   (out, ROW_W)         - tile row (clamped to ROWS-1 outside the grid)
//   col   (out, COL_W)         - tile column (clamped to COLS-1 outside the grid)
//   in_grid   (out, 1)         - coordinate lies inside the tiled area
//   on_border (out, 1)         - in-grid pixel on a tile's first row/column
// -----------------------------------------------------------------------------
module maze_tile_locator #(
    parameter int ROWS    = 4,
    parameter int COLS    = 5,
    parameter int TILE_PX = 50,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int COL_W  = $clog2(COLS)
) (
    input  logic [9:0]       pixel_x,
    input  logic [9:0]       pixel_y,
    output logic [ROW_W-1:0] row,
    output logic [COL_W-1:0] col,
    output logic             in_grid,
    output logic             on_border
);

    // Compare chain: the last tile multiple not exceeding the coordinate wins.
    always_comb begin
        row = {ROW_W{1'b0}};
        col = {COL_W{1'b0}};
        for (int k = 1; k < ROWS; k++) begin
            row = (pixel_y >= 10'(k * TILE_PX)) ? ROW_W'(k) : row;
        end
        for (int k = 1; k < COLS; k++) begin
            col = (pixel_x >= 10'(k * TILE_PX)) ? COL_W'(k) : col;
        end
        in_grid = (pixel_x < 10'(COLS * TILE_PX)) && (pixel_y < 10'(ROWS * TILE_PX));
    end

`ifdef MAZE_GRID_BORDER_EN
    // A pixel sits on a border when either coordinate equals a tile multiple.
    always_comb begin
        logic on_x;
        logic on_y;
        on_x = 1'b0;
        on_y = 1'b0;
        for (int k = 0; k < COLS; k++) begin
            on_x = on_x | (pixel_x == 10'(k * TILE_PX));
        end
        for (int k = 0; k < ROWS; k++) begin
            on_y = on_y | (pixel_y == 10'(k * TILE_PX));
        end
        on_border = in_grid && (on_x || on_y);
    end
`else
    assign on_border = 1'b0;
`endif

endmodule

// File: rtl/maze_grid_tracker.sv
// -----------------------------------------------------------------------------
// maze_grid_tracker
// Maze-state store and tile renderer. Accepts MOVE / MARK_FUTURE / CLEAR_ALL
// packets over a valid/ready handshake, keeps a ROWS x COLS grid of 2-bit cell
// states, tracks the robot cell and renders a registered RRRGGGBB colour for
// each VGA coordinate (1-cycle latency). CLEAR_ALL runs a one-cell-per-cycle
// row-major sweep during which PKT_READY is low.
// Optional feature macro: MAZE_GRID_BORDER_EN (white tile borders).
// Ports:
//   CLOCK, RESET (sync, active high)
//   PKT_VALID/PKT_READY, PKT_KIND[1:0], PKT_ROW, PKT_COL - packet interface
//   PIXEL_X/PIXEL_Y[9:0] in, PIXEL_COLOR[7:0] out      - render interface
//   CUR_VALID, CUR_ROW, CUR_COL                        - robot position
//   VISITED_COUNT                                      - cells VISITED/CURRENT
// -----------------------------------------------------------------------------
module maze_grid_tracker
    import maze_grid_pkg::*;
#(
    parameter int ROWS    = 4,
    parameter int COLS    = 5,
    parameter int TILE_PX = 50,
    localparam int ROW_W  = $clog2(ROWS),
    localparam int COL_W  = $clog2(COLS),
    localparam int CNT_W  = $clog2(ROWS * COLS + 1)
) (
    input  logic             CLOCK,
    input  logic             RESET,
    input  logic             PKT_VALID,
    output logic             PKT_READY,
    input  logic [1:0]       PKT_KIND,
    input  logic [ROW_W-1:0] PKT_ROW,
    input  logic [COL_W-1:0] PKT_COL,
    input  logic [9:0]       PIXEL_X,
    input  logic [9:0]       PIXEL_Y,
    output logic [7:0]       PIXEL_COLOR,
    output logic             CUR_VALID,
    output logic [ROW_W-1:0] CUR_ROW,
    output logic [COL_W-1:0] CUR_COL,
    output logic [CNT_W-1:0] VISITED_COUNT
);

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(ROWS * COLS);

    tracker_state_t   state_r, state_s;
    cell_state_t      grid_r [ROWS][COLS];
    logic             cur_valid_r;
    logic [ROW_W-1:0] cur_row_r, sweep_row_r, tgt_row_s, pix_row_s;
    logic [COL_W-1:0] cur_col_r, sweep_col_r, tgt_col_s, pix_col_s;
    logic [CNT_W-1:0] count_r;
    logic [7:0]       color_r;
    logic             accept_s, in_range_s, sweep_last_s, same_cell_s;
    logic             in_grid_s, on_border_s;
    pkt_kind_t        kind_s;
    cell_state_t      tgt_state_s;

    maze_tile_locator #(.ROWS(ROWS), .COLS(COLS), .TILE_PX(TILE_PX)) u_locator (
        .pixel_x   (PIXEL_X),
        .pixel_y   (PIXEL_Y),
        .row       (pix_row_s),
        .col       (pix_col_s),
        .in_grid   (in_grid_s),
        .on_border (on_border_s)
    );

    // Packet decode; out-of-range targets are redirected to (0,0) so the grid
    // read stays in bounds, and in_range_s suppresses any effect.
    always_comb begin
        accept_s     = PKT_VALID && (state_r == ST_IDLE);
        kind_s       = pkt_kind_t'(PKT_KIND);
        in_range_s   = (32'(PKT_ROW) < 32'(ROWS)) && (32'(PKT_COL) < 32'(COLS));
        sweep_last_s = (sweep_row_r == ROW_W'(ROWS - 1)) && (sweep_col_r == COL_W'(COLS - 1));
        if (in_range_s) begin
            tgt_row_s = PKT_ROW;
            tgt_col_s = PKT_COL;
        end else begin
            tgt_row_s = {ROW_W{1'b0}};
            tgt_col_s = {COL_W{1'b0}};
        end
        tgt_state_s = grid_r[tgt_row_s][tgt_col_s];
        same_cell_s = (cur_row_r == tgt_row_s) && (cur_col_r == tgt_col_s);
    end

    // FSM state register.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: a valid in-range CLEAR_ALL starts the sweep, the final
    // cell write ends it.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s && in_range_s && (kind_s == KIND_CLEAR_ALL)) begin
                    state_s = ST_SWEEP;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_SWEEP: begin
                if (sweep_last_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_SWEEP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // Grid, robot position, visited counter and sweep cursor.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            for (int r = 0; r < ROWS; r++) begin
                for (int c = 0; c < COLS; c++) begin
                    grid_r[r][c] <= CELL_UNVISITED;
                end
            end
            cur_valid_r <= 1'b0;
            cur_row_r   <= {ROW_W{1'b0}};
            cur_col_r   <= {COL_W{1'b0}};
            count_r     <= {CNT_W{1'b0}};
            sweep_row_r <= {ROW_W{1'b0}};
            sweep_col_r <= {COL_W{1'b0}};
        end else if (state_r == ST_SWEEP) begin
            grid_r[sweep_row_r][sweep_col_r] <= CELL_UNVISITED;
            if (sweep_col_r == COL_W'(COLS - 1)) begin
                sweep_col_r <= {COL_W{1'b0}};
                sweep_row_r <= sweep_row_r + ROW_W'(1);
            end else begin
                sweep_col_r <= sweep_col_r + COL_W'(1);
            end
        end else if (accept_s && in_range_s) begin
            case (kind_s)
                KIND_MOVE: begin
                    if (!(cur_valid_r && same_cell_s)) begin
                        if (cur_valid_r) begin
                            grid_r[cur_row_r][cur_col_r] <= CELL_VISITED;
                        end
                        grid_r[tgt_row_s][tgt_col_s] <= CELL_CURRENT;
                        cur_row_r   <= tgt_row_s;
                        cur_col_r   <= tgt_col_s;
                        cur_valid_r <= 1'b1;
                        // Re-entering a VISITED cell does not add to the count.
                        if (((tgt_state_s == CELL_UNVISITED) || (tgt_state_s == CELL_FUTURE))
                            && (count_r != CNT_MAX)) begin
                            count_r <= count_r + CNT_W'(1);
                        end
                    end
                end
                KIND_MARK_FUTURE: begin
                    if (tgt_state_s == CELL_UNVISITED) begin
                        grid_r[tgt_row_s][tgt_col_s] <= CELL_FUTURE;
                    end
                end
                KIND_CLEAR_ALL: begin
                    cur_valid_r <= 1'b0;
                    count_r     <= {CNT_W{1'b0}};
                    sweep_row_r <= {ROW_W{1'b0}};
                    sweep_col_r <= {COL_W{1'b0}};
                end
                default: begin
                end
            endcase
        end
    end

    // Registered pixel colour; border (when enabled) overrides the cell colour.
    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            color_r <= COLOR_BG;
        end else if (!in_grid_s) begin
            color_r <= COLOR_BG;
        end else if (on_border_s) begin
            color_r <= COLOR_BORDER;
        end else begin
            color_r <= cell_color(grid_r[pix_row_s][pix_col_s]);
        end
    end

    assign PKT_READY     = (state_r == ST_IDLE);
    assign PIXEL_COLOR   = color_r;
    assign CUR_VALID     = cur_valid_r;
    assign CUR_ROW       = cur_row_r;
    assign CUR_COL       = cur_col_r;
    assign VISITED_COUNT = count_r;

endmodule
